// File: rtl/conv_8x32_pkg.sv
// Shared types and defaults for the conv_8x32 max-pooling stage.
package conv_8x32_pkg;

   // Default element width of the conv_8x32 result stream.
   localparam int unsigned CONV_DATA_WIDTH = 8;

   // Default number of elements per pooling window.
   localparam int unsigned CONV_WINDOW = 4;

   // Index width that goes with the default window.
   localparam int unsigned CONV_IDX_WIDTH = $clog2(CONV_WINDOW);

   // Pooling FSM: collect a window, then present its result.
   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } pool_state_t;

   // Result record for consumers using the default geometry.
   typedef struct packed {
      logic [CONV_DATA_WIDTH-1:0] max;
      logic [CONV_IDX_WIDTH-1:0]  idx;
   } pool_result_t;

   // Bundles a max value and its index into one result record.
   function automatic pool_result_t pool_pack(
      input logic [CONV_DATA_WIDTH-1:0] max_v,
      input logic [CONV_IDX_WIDTH-1:0]  idx_v
   );
      pool_result_t res;
      res.max = max_v;
      res.idx = idx_v;
      return res;
   endfunction

endpackage

// File: rtl/conv_8x32_comp_less.sv
// Unsigned magnitude comparator: d_out is high when a_in is strictly below b_in.
// Strictly-less means an equal newcomer never displaces the running maximum.
module conv_8x32_comp_less
   import conv_8x32_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic                  d_out
);

   assign d_out = (a_in < b_in);

endmodule

// File: rtl/conv_8x32_max_pool.sv
// Streaming max-pool over fixed windows of WINDOW unsigned elements.
// Emits {max, index-of-first-max} per window, then waits for the consumer.
module conv_8x32_max_pool
   import conv_8x32_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
   parameter int unsigned WINDOW     = CONV_WINDOW
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_max,
   output logic [$clog2(WINDOW)-1:0]     out_idx
);

   localparam int unsigned IDX_WIDTH = $clog2(WINDOW);
   localparam logic [IDX_WIDTH-1:0]  CNT_ZERO  = {IDX_WIDTH{1'b0}};
   localparam logic [IDX_WIDTH-1:0]  CNT_ONE   = IDX_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0]  CNT_LAST  = IDX_WIDTH'(WINDOW - 1);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   pool_state_t           state_q;
   logic [IDX_WIDTH-1:0]  cnt_q;
   logic [IDX_WIDTH-1:0]  cnt_d;
   logic [DATA_WIDTH-1:0] max_q;
   logic [DATA_WIDTH-1:0] max_d;
   logic [IDX_WIDTH-1:0]  idx_q;
   logic [IDX_WIDTH-1:0]  idx_d;
   logic                  in_ready_q;
   logic                  out_valid_q;

   logic                  in_accum_s;
   logic                  accept_s;
   logic                  abort_s;
   logic                  last_s;
   logic                  less_s;

   // Running max is compared against each new element after the first.
   conv_8x32_comp_less #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_comp_less (
      .a_in  (max_q),
      .b_in  (in_data),
      .d_out (less_s)
   );

   // clr wins over a same-cycle input, so an aborting cycle never accepts.
   assign in_accum_s = (state_q == ACCUM);
   assign abort_s    = in_accum_s & clr;
   assign accept_s   = in_accum_s & in_valid & ~clr;
   assign last_s     = (cnt_q == CNT_LAST);

   // Next-state of the counter and the running max/index registers.
   always_comb begin
      cnt_d = cnt_q;
      max_d = max_q;
      idx_d = idx_q;
      if (accept_s) begin
         if ((cnt_q == CNT_ZERO) || less_s) begin
            max_d = in_data;
            idx_d = cnt_q;
         end else begin
            max_d = max_q;
            idx_d = idx_q;
         end
         if (last_s) begin
            cnt_d = CNT_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (abort_s) begin
         cnt_d = CNT_ZERO;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pooling FSM with registered handshake outputs and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         cnt_q       <= CNT_ZERO;
         max_q       <= DATA_ZERO;
         idx_q       <= CNT_ZERO;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         max_q <= max_d;
         idx_q <= idx_d;
         case (state_q)
            ACCUM: begin
               if (accept_s && last_s) begin
                  state_q     <= HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q     <= ACCUM;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= ACCUM;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end else begin
                  state_q     <= HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ACCUM;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_max   = max_q;
   assign out_idx   = idx_q;

endmodule

// File: tb/tb_conv_8x32_max_pool.sv
// Directed self-checking bench for conv_8x32_max_pool (DATA_WIDTH=8, WINDOW=4).
module tb_conv_8x32_max_pool;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_max;
   logic [1:0] out_idx;

   int total = 0;
   int bad   = 0;

   conv_8x32_max_pool #(
      .DATA_WIDTH (8),
      .WINDOW     (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_idx   (out_idx)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one element for exactly one clock edge.
   task automatic push(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_max !== 8'h00)  begin bad++; $display("FAIL reset_out_max got=%h exp=00", out_max); end
      total++; if (out_idx !== 2'd0)   begin bad++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      push(8'h10);
      push(8'h40);
      push(8'h20);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
      push(8'h30);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL basic_in_ready got=%b exp=0", in_ready); end
      total++; if (out_max !== 8'h40)  begin bad++; $display("FAIL basic_max got=%h exp=40", out_max); end
      total++; if (out_idx !== 2'd1)   begin bad++; $display("FAIL basic_idx got=%0d exp=1", out_idx); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
   endtask

   task automatic test_tie();
      out_ready = 1'b1;
      push(8'h55);
      push(8'h55);
      push(8'h10);
      push(8'h55);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL tie_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'h55)  begin bad++; $display("FAIL tie_max got=%h exp=55", out_max); end
      total++; if (out_idx !== 2'd0)   begin bad++; $display("FAIL tie_idx got=%0d exp=0", out_idx); end
      step();
   endtask

   task automatic test_unsigned();
      out_ready = 1'b1;
      push(8'h7F);
      push(8'h80);
      push(8'h00);
      push(8'hFF);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL unsigned_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'hFF)  begin bad++; $display("FAIL unsigned_max got=%h exp=ff", out_max); end
      total++; if (out_idx !== 2'd3)   begin bad++; $display("FAIL unsigned_idx got=%0d exp=3", out_idx); end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push(8'h01);
      push(8'h09);
      push(8'h03);
      push(8'h02);
      // Offer extra data while the result is stalled; it must not be taken.
      in_valid = 1'b1;
      in_data  = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
         total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         total++; if (out_max !== 8'h09)  begin bad++; $display("FAIL bp_max cyc=%0d got=%h exp=09", i, out_max); end
         total++; if (out_idx !== 2'd1)   begin bad++; $display("FAIL bp_idx cyc=%0d got=%0d exp=1", i, out_idx); end
         step();
      end
      // Handshake cycle with in_valid still high: EE must still be ignored.
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      push(8'h05);
      push(8'h06);
      push(8'h07);
      push(8'h08);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'h08)  begin bad++; $display("FAIL bp_next_max got=%h exp=08", out_max); end
      total++; if (out_idx !== 2'd3)   begin bad++; $display("FAIL bp_next_idx got=%0d exp=3", out_idx); end
      step();
   endtask

   task automatic test_clr();
      out_ready = 1'b1;
      push(8'hAA);
      push(8'hBB);
      // Abort with an element presented in the same cycle; it is dropped.
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hCC;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clr_in_ready got=%b exp=1", in_ready); end
      step();
      clr      = 1'b0;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_no_valid got=%b exp=0", out_valid); end
      push(8'h01);
      push(8'h02);
      push(8'h03);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_early_valid got=%b exp=0", out_valid); end
      push(8'h04);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'h04)  begin bad++; $display("FAIL clr_max got=%h exp=04", out_max); end
      total++; if (out_idx !== 2'd3)   begin bad++; $display("FAIL clr_idx got=%0d exp=3", out_idx); end
      step();
   endtask

   task automatic test_clr_in_hold();
      out_ready = 1'b0;
      push(8'h21);
      push(8'h63);
      push(8'h42);
      push(8'h11);
      clr = 1'b1;
      step();
      clr = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_clr_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'h63)  begin bad++; $display("FAIL hold_clr_max got=%h exp=63", out_max); end
      total++; if (out_idx !== 2'd1)   begin bad++; $display("FAIL hold_clr_idx got=%0d exp=1", out_idx); end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_rst_mid();
      out_ready = 1'b1;
      push(8'h90);
      push(8'h91);
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
      total++; if (out_max !== 8'h00)  begin bad++; $display("FAIL rstmid_max got=%h exp=00", out_max); end
      push(8'h03);
      push(8'h01);
      push(8'h02);
      push(8'h00);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_win_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'h03)  begin bad++; $display("FAIL rstmid_win_max got=%h exp=03", out_max); end
      total++; if (out_idx !== 2'd0)   begin bad++; $display("FAIL rstmid_win_idx got=%0d exp=0", out_idx); end
      step();
   endtask

   task automatic test_rst_hold();
      out_ready = 1'b0;
      push(8'h10);
      push(8'h20);
      push(8'h30);
      push(8'h40);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rsthold_pre_valid got=%b exp=1", out_valid); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rsthold_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rsthold_ready got=%b exp=1", in_ready); end
      total++; if (out_max !== 8'h00)  begin bad++; $display("FAIL rsthold_max got=%h exp=00", out_max); end
      total++; if (out_idx !== 2'd0)   begin bad++; $display("FAIL rsthold_idx got=%0d exp=0", out_idx); end
      out_ready = 1'b1;
      push(8'h0A);
      push(8'h0B);
      push(8'h0C);
      push(8'h01);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rsthold_win_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'h0C)  begin bad++; $display("FAIL rsthold_win_max got=%h exp=0c", out_max); end
      total++; if (out_idx !== 2'd2)   begin bad++; $display("FAIL rsthold_win_idx got=%0d exp=2", out_idx); end
      step();
   endtask

   task automatic test_bubbles();
      out_ready = 1'b1;
      push(8'h33);
      step();
      step();
      push(8'h44);
      step();
      push(8'h22);
      push(8'h11);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bubble_valid got=%b exp=1", out_valid); end
      total++; if (out_max !== 8'h44)  begin bad++; $display("FAIL bubble_max got=%h exp=44", out_max); end
      total++; if (out_idx !== 2'd1)   begin bad++; $display("FAIL bubble_idx got=%0d exp=1", out_idx); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_unsigned();
      test_backpressure();
      test_clr();
      test_clr_in_hold();
      test_rst_mid();
      test_rst_hold();
      test_bubbles();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
